halftone_stream_reader: RTL and testbench
=========================================

Name: halftone_stream_reader

Overview:
- Reads the finished 1-byte-per-pixel halftone image back out of the image RAM after error diffusion completes (start is driven by diff_done).
- Packs pixels to 1 bit each: 8 pixels per byte, MSB first.
- Streams the packed bytes on a valid/ready master interface toward the display/UART/host export path.
- Sole RAM reader during export; the diffusion engine is idle while this block is busy.

Parameters:
- IMG_W, 512, image width in pixels; must be a multiple of 8.
- IMG_H, 512, image height in pixels.
- ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a frame export; ignored while busy=1.
- ram_ren  output  1  RAM read enable.
- ram_addr  output  ADDR_W  RAM read address; linear, row-major: addr = row*IMG_W + col.
- ram_odata  input  8  RAM read data; valid exactly 1 cycle after the ram_ren cycle.
- m_valid  output  1  output byte valid.
- m_ready  input  1  downstream accept.
- m_data  output  8  packed pixels; bit7 = lowest address of the group.
- m_last  output  1  high together with the final byte of the frame.
- busy  output  1  export in progress.
- done  output  1  one-cycle pulse when the final byte is accepted.

Behaviour:
- Reset values: ram_ren=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. Internal bit_cnt, inflight, pixel counter and state are cleared.
- Reset mid-frame aborts the export immediately: no further reads, and any pending byte is discarded.
- States:
  - IDLE: on start go to READ; busy<=1; rd_addr<=0.
  - READ: issues reads. When rd_addr reaches IMG_W*IMG_H with no read in flight, go to FLUSH.
  - FLUSH: wait until the final byte has been handshaken, then go to IDLE; busy<=0; done pulses for 1 cycle in the same cycle busy falls.
- Read issue:
  - ram_ren=1 in READ when (bit_cnt + inflight) < 8 and rd_addr < IMG_W*IMG_H.
  - ram_addr = rd_addr.
  - rd_addr increments per issued read.
  - inflight<=ram_ren.
  - ram_ren and ram_addr are registered or combinational from registers; no combinational path from m_ready to ram_ren.
- Capture: in the cycle after a read, shift register pack <= {pack[6:0], ram_odata[7]}; bit_cnt++. A pixel of 128 or more maps to 1, otherwise 0.
- Transfer to output:
  - Condition: bit_cnt==8 and (m_valid==0 or m_ready==1).
  - Action: m_data<=pack; m_valid<=1; bit_cnt<=0.
  - m_last<=1 iff this is byte number IMG_W*IMG_H/8 - 1.
- Handshake:
  - A byte transfers on a cycle where m_valid && m_ready are both high.
  - m_data and m_last are held stable while m_valid && !m_ready.
  - m_valid drops after acceptance unless a new byte is loaded in the same cycle; back-to-back transfer is legal.
- Backpressure: with m_valid held, pack fills to 8 and reads stall. No pixel is ever lost or duplicated, and there is no RAM over-read.
- Throughput with m_ready=1: one byte per 10 cycles at most.
- Latency:
  - First ram_ren is 1 cycle after the start pulse.
  - First m_valid occurs 10 cycles after start.
- Simultaneous events:
  - start in the same cycle as done is ignored.
  - start while busy is ignored entirely and does not restart the export.
- Byte count per frame: exactly IMG_W*IMG_H/8 (32768 at default).
- Row boundaries need no special handling, because IMG_W is a multiple of 8 and bytes never straddle rows.

Test Plan:
- Basic (IMG_W=16, IMG_H=2): RAM preloaded with 0xFF,0x00 alternating; start with m_ready=1 -> 4 bytes of 0xAA; m_last high on the 4th only; done pulses once; exactly 32 ram_ren cycles at addresses 0..31.
- Threshold: pixels 127,128,0,255,129,1,200,50 -> m_data=0x5A.
- Backpressure (IMG_W=16, IMG_H=2): random m_ready at 30% duty -> byte sequence identical to the m_ready=1 run; m_data stable while stalled; no ram_ren while bit_cnt=8 and m_valid && !m_ready.
- Mid-frame: start pulses during busy -> ignored, still 4 bytes and one done. Then rst_n low mid-frame -> all outputs 0 within the reset; the next start exports the full frame from address 0.
- Full default 512x512: random image, compared to a bit-packed model -> 32768 bytes; m_last only on byte 32767; final ram_addr=262143; done after the last handshake.
- Timing with m_ready=1: first ram_ren 1 cycle after start; first m_valid at cycle 10; successive bytes 10 cycles apart.

Source files
------------

// File: rtl/halftone_stream_reader_if.sv
// Packed-pixel byte stream: valid/ready handshake, a byte moves on a clock edge
// where m_valid && m_ready; the master holds m_data/m_last stable while stalled.
interface halftone_stream_reader_if;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/halftone_stream_reader.sv
// Reads the 8-bit halftone image from RAM, thresholds each pixel to 1 bit,
// packs 8 pixels per byte (MSB = lowest address) and streams the bytes out.
module halftone_stream_reader #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     ram_ren,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [7:0]               ram_odata,
    halftone_stream_reader_if.master m_if,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               o_state_dbg
);
    localparam int unsigned NPIX_I  = IMG_W * IMG_H;
    localparam int unsigned LAST_I  = NPIX_I / 8 - 1;
    localparam logic [ADDR_W:0]   NPIX      = NPIX_I[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_BYTE = LAST_I[ADDR_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_rd_addr;   // one extra bit so it can hold NPIX itself
    logic [3:0]        r_bit_cnt;
    logic              r_inflight;
    logic [7:0]        r_pack;
    logic [ADDR_W-1:0] r_byte_cnt;

    logic [3:0] w_fill;
    logic       w_ren;
    logic       w_pix;
    logic       w_accept;
    logic       w_load;

    // Bits captured plus the one read still in flight must not exceed one byte.
    assign w_fill   = r_bit_cnt + {3'b000, r_inflight};
    assign w_ren    = (r_state == S_READ) && (w_fill < 4'd8) && (r_rd_addr < NPIX);
    assign w_pix    = (ram_odata >= 8'd128);
    assign w_accept = m_if.m_valid && m_if.m_ready;
    assign w_load   = (r_bit_cnt == 4'd8) && (!m_if.m_valid || m_if.m_ready);

    assign ram_ren     = w_ren;
    assign ram_addr    = r_rd_addr[ADDR_W-1:0];
    assign o_state_dbg = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_bit_cnt    <= 4'd0;
            r_inflight   <= 1'b0;
            r_pack       <= 8'd0;
            r_byte_cnt   <= '0;
            m_if.m_valid <= 1'b0;
            m_if.m_data  <= 8'd0;
            m_if.m_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done       <= 1'b0;
            r_inflight <= w_ren;
            if (w_ren) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (r_inflight) begin
                r_pack    <= {r_pack[6:0], w_pix};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_accept) begin
                m_if.m_valid <= 1'b0;
                m_if.m_last  <= 1'b0;
            end
            // A load in the same cycle as an accept overrides the drop above.
            if (w_load) begin
                m_if.m_data  <= r_pack;
                m_if.m_valid <= 1'b1;
                m_if.m_last  <= (r_byte_cnt == LAST_BYTE);
                r_byte_cnt   <= r_byte_cnt + 1'b1;
                r_bit_cnt    <= 4'd0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start && !done) begin
                        r_state    <= S_READ;
                        busy       <= 1'b1;
                        r_rd_addr  <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                S_READ: begin
                    if ((r_rd_addr == NPIX) && !r_inflight) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_accept && m_if.m_last) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_halftone_stream_reader.sv
// Directed bench for halftone_stream_reader on a 16x2 image with a 1-cycle RAM model.
module tb_halftone_stream_reader;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 5;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBYTE  = NPIX / 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              ram_ren;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_odata;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    halftone_stream_reader_if m_if ();

    halftone_stream_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ram_ren     (ram_ren),
        .ram_addr    (ram_addr),
        .ram_odata   (ram_odata),
        .m_if        (m_if),
        .busy        (busy),
        .done        (done),
        .o_state_dbg (state_dbg)
    );

    // ---------------- clock / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [NPIX];
    always @(posedge clk) begin
        if (ram_ren) ram_odata <= mem[ram_addr];
    end

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       last_q[$];
    int         ren_cnt, exp_addr, done_cnt;
    bit         mon_en = 1'b0;
    int         ready_mode = 0;
    bit         prev_stall, last_pending;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int b);
        logic [7:0] v;
        v = 8'd0;
        for (int k = 0; k < 8; k++) v = {v[6:0], (mem[b*8+k] >= 8'd128)};
        return v;
    endfunction

    // Monitor + ready driver: everything sampled mid-cycle, ahead of the next edge.
    always @(negedge clk) begin
        if (!mon_en) begin
            m_if.m_ready = 1'b1;
        end else begin
            if (last_pending) begin
                check_eq("done_after_last", 32'(done), 32'd1);
                last_pending = 1'b0;
            end
            if (done) done_cnt++;
            if (ram_ren) begin
                check_eq("ram_addr", 32'(ram_addr), 32'(exp_addr));
                exp_addr++;
                ren_cnt++;
            end
            if (prev_stall) begin
                check_eq("stall_valid", 32'(m_if.m_valid), 32'd1);
                check_eq("stall_data", 32'(m_if.m_data), 32'(prev_data));
                check_eq("stall_last", 32'(m_if.m_last), 32'(prev_last));
            end
            m_if.m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
            if (m_if.m_valid && m_if.m_ready) begin
                got_q.push_back(m_if.m_data);
                last_q.push_back(m_if.m_last);
                if (m_if.m_last) last_pending = 1'b1;
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_alt();
        for (int i = 0; i < NPIX; i++) mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    endtask

    task automatic run_frame(input string tag, input int mode, input bit poke, input bit timing);
        int cyc;
        int first_ren;
        int v_cyc[$];
        logic prev_v;
        exp_q.delete(); got_q.delete(); last_q.delete();
        for (int b = 0; b < NBYTE; b++) exp_q.push_back(model_byte(b));
        ren_cnt = 0; exp_addr = 0; done_cnt = 0;
        prev_stall = 1'b0; last_pending = 1'b0;
        ready_mode = mode;
        first_ren = 0; prev_v = 1'b0; cyc = 0;
        @(negedge clk);
        mon_en = 1'b1;
        start  = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            // Extra starts while busy, and one in the cycle done is high, must be ignored.
            start = poke && (((cyc % 17) == 5) || done);
            if (ram_ren && first_ren == 0) first_ren = cyc;
            if (m_if.m_valid && !prev_v) v_cyc.push_back(cyc);
            prev_v = m_if.m_valid;
        end while (!done && cyc < 2000);
        start = 1'b0;
        check_eq({tag, "_finished"}, 32'(cyc < 2000), 32'd1);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check_eq({tag, "_byte_count"}, 32'(got_q.size()), 32'(NBYTE));
        for (int i = 0; i < got_q.size() && i < NBYTE; i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == NBYTE - 1));
        end
        check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_ren_count"}, 32'(ren_cnt), 32'(NPIX));
        check_eq({tag, "_idle_after"}, {29'd0, busy, m_if.m_valid, ram_ren}, 32'd0);
        check_eq({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
        if (timing) begin
            // m_valid is registered: first seen at cycle 11 means it was loaded by edge 10.
            check_eq("first_ren_cycle", 32'(first_ren), 32'd1);
            check_eq("valid_pulses", 32'(v_cyc.size()), 32'(NBYTE));
            if (v_cyc.size() > 0) check_eq("first_valid_edge", 32'(v_cyc[0] - 1), 32'd10);
            for (int i = 1; i < v_cyc.size(); i++)
                check_eq($sformatf("byte_spacing%0d", i), 32'(v_cyc[i] - v_cyc[i-1]), 32'd10);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        load_alt();
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {17'd0, ram_ren, ram_addr, m_if.m_valid, m_if.m_data, m_if.m_last, busy, done},
                 32'd0);
        check_eq("reset_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Alternating 0xFF/0x00 packs to 0xAA, with full-rate timing checks.
        run_frame("basic", 0, 1'b0, 1'b1);
        if (got_q.size() > 0) check_eq("basic_hand_aa", 32'(got_q[0]), 32'h0000_00AA);

        // Threshold boundary pixels, hand-packed to 0x5A.
        mem[0] = 8'd127; mem[1] = 8'd128; mem[2] = 8'd0;   mem[3] = 8'd255;
        mem[4] = 8'd129; mem[5] = 8'd1;   mem[6] = 8'd200; mem[7] = 8'd50;
        run_frame("thresh", 0, 1'b0, 1'b0);
        if (got_q.size() > 0) check_eq("thresh_hand_5a", 32'(got_q[0]), 32'h0000_005A);

        // Random 30% ready duty on the alternating image.
        load_alt();
        run_frame("bp", 1, 1'b0, 1'b0);
        for (int i = 0; i < got_q.size(); i++)
            check_eq($sformatf("bp_hand_aa%0d", i), 32'(got_q[i]), 32'h0000_00AA);

        // Start pulses while busy and during done.
        run_frame("poke", 0, 1'b1, 1'b0);

        // Reset mid-frame, then a clean full frame from address 0.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_outputs",
                 {17'd0, ram_ren, ram_addr, m_if.m_valid, m_if.m_data, m_if.m_last, busy, done},
                 32'd0);
        @(negedge clk);
        check_eq("midrst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame("after_rst", 0, 1'b0, 1'b0);

        // Random image under random backpressure against the bit-pack model.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
        run_frame("rand", 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
